// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter width; kept at least 1 so the counter always exists.
  function automatic int cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one bit per cycle, LSB first, WIDTH-cycle latency.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d_bit, br_nxt;
  logic             last;

  assign last = (cnt == LAST);

  full_subtractor u_fs (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .bin (br),
    .d   (d_bit),
    .bout(br_nxt)
  );

  // Next-state and status outputs; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath: latch operands on start, then shift one bit per RUN cycle.
  // bout keeps the previous result until the final bit of the new one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sr <= a;
      b_sr <= b;
      br   <= bin;
      cnt  <= '0;
      diff <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      br   <= br_nxt;
      diff <= {d_bit, diff[WIDTH-1:1]};
      cnt  <= cnt + CW'(1);
      if (last) bout <= br_nxt;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: vector table, corner sequences, random vs. model,
// and an exhaustive sweep of a 4-bit instance.
module tb_serial_subtractor;

  localparam int W  = 8;
  localparam int W4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, bin, busy, done, bout;
  logic [W-1:0] a, b, diff;

  logic          start4, bin4, busy4, done4, bout4;
  logic [W4-1:0] a4, b4, diff4;

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  serial_subtractor #(.WIDTH(W4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  typedef struct {
    logic [W-1:0] a, b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer subtraction, borrow when the result goes negative.
  function automatic logic [32:0] model(input int w, input int av, input int bv, input int cv);
    int r;
    logic [31:0] m;
    r = av - bv - cv;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return {r < 0, 32'(r) & m};
  endfunction

  // Runs one op on the 8-bit DUT starting at a negedge; returns at the
  // negedge of the IDLE cycle after DONE (ready for a back-to-back start).
  task automatic run8(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                      output logic [W-1:0] rd, output logic rb, output int lat);
    a = ai; b = bi; bin = ci; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    chk("busy_after_start", busy, 1);
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    if (!done) begin
      failures++;
      $display("FAIL timeout waiting for done actual=0 expected=1");
    end
    rd = diff; rb = bout;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  task automatic run4(input logic [W4-1:0] ai, input logic [W4-1:0] bi, input logic ci,
                      output logic [W4-1:0] rd, output logic rb);
    int n;
    a4 = ai; b4 = bi; bin4 = ci; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    a4 = W4'($urandom); b4 = W4'($urandom);
    n = 0;
    while (n < 20 && !done4) begin
      @(negedge clk);
      n++;
    end
    if (!done4) begin
      failures++;
      $display("FAIL timeout4 waiting for done actual=0 expected=1");
    end
    rd = diff4; rb = bout4;
    @(negedge clk);
  endtask

  initial begin
    vec_t         tbl[7];
    logic [W-1:0] rd;
    logic         rb;
    logic [W4-1:0] rd4;
    logic          rb4;
    logic [32:0]   exp;
    int lat, pulses;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b0};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    tbl[6] = '{8'h37, 8'h37, 1'b0, 8'h00, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_busy4", busy4, 0);

    // First start coincides with the first edge with reset released;
    // table entries run back to back (each start in the IDLE after DONE).
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      run8(tbl[i].a, tbl[i].b, tbl[i].bin, rd, rb, lat);
      chk($sformatf("tbl%0d_latency", i), lat, W);
      chk($sformatf("tbl%0d_diff", i), rd, tbl[i].d);
      chk($sformatf("tbl%0d_bout", i), rb, tbl[i].bo);
    end

    // Result holds while idle.
    repeat (5) @(negedge clk);
    chk("hold_diff", diff, tbl[6].d);
    chk("hold_bout", bout, tbl[6].bo);

    // start during RUN is ignored and not queued.
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; rd = '0; rb = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (done) begin pulses++; rd = diff; rb = bout; end
    end
    chk("ignore_pulses", pulses, 1);
    chk("ignore_diff", rd, 8'h1E);
    chk("ignore_bout", rb, 0);

    // Reset in RUN cycle 4 aborts with no done afterwards.
    a = 8'h5A; b = 8'h3C; bin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    rst_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rbv;
      logic         rc;
      ra = W'($urandom); rbv = W'($urandom); rc = 1'($urandom);
      exp = model(W, int'(ra), int'(rbv), int'(rc));
      run8(ra, rbv, rc, rd, rb, lat);
      chk("rand_latency", lat, W);
      chk("rand_diff", rd, exp[31:0]);
      chk("rand_bout", rb, exp[32]);
    end

    // Exhaustive 4-bit sweep.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) begin
          exp = model(W4, x, y, c);
          run4(W4'(x), W4'(y), 1'(c), rd4, rb4);
          chk("exh4_diff", rd4, exp[31:0]);
          chk("exh4_bout", rb4, exp[32]);
        end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and difference width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH bits: minuend; sampled with start.
REQ-006 SHALL have port b, input, WIDTH bits: subtrahend; sampled with start.
REQ-007 SHALL have port bin, input, 1 bit: borrow-in; sampled with start.
REQ-008 SHALL have port busy, output, 1 bit: high while the operation is in RUN or DONE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking diff/bout valid.
REQ-010 SHALL have port diff, output, WIDTH bits: result a - b - bin, modulo 2^WIDTH.
REQ-011 SHALL have port bout, output, 1 bit: borrow-out, set when a < b + bin (unsigned).

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE to RUN SHALL occur at the edge where start=1; at that edge a, b and bin are latched into internal shift registers, the bit counter is cleared and diff is cleared.
REQ-014 In RUN, each edge SHALL process one bit, LSB first, as follows:
- d = a_i ^ b_i ^ br
- br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
- d is shifted into diff from the MSB side.
- The counter increments.
REQ-015 RUN to DONE SHALL occur at the edge processing bit WIDTH-1; at that edge bout is updated to the final borrow.
REQ-016 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL move to IDLE at the next edge.
REQ-017 Latency SHALL be exactly WIDTH cycles from the start-sampling edge to the first cycle with done=1.
REQ-018 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-019 diff and bout SHALL hold their last result in IDLE until the next accepted start.
REQ-020 start SHALL be ignored in RUN and DONE: it is neither queued nor allowed to disturb the operation.
REQ-021 Back-to-back operation: start asserted in the IDLE cycle immediately after DONE SHALL be accepted, giving a throughput of one result per WIDTH+1 cycles.
REQ-022 Changes on a, b or bin after the start-sampling edge SHALL have no effect on the result in progress.
REQ-023 Boundary cases SHALL be handled without special-casing:
- a=b with bin=0 gives diff=0, bout=0.
- a=0, b=0, bin=1 gives diff all ones, bout=1.

Reset
REQ-024 When rst_n=0 at a rising edge, the FSM SHALL go to IDLE and busy, done, diff, bout, the counter, the borrow register and the operand registers SHALL all be 0.
REQ-025 Reset during RUN or DONE SHALL abort the operation, and no done pulse SHALL follow.
REQ-026 The first start SHALL be accepted at the first edge with rst_n=1.

Structure
REQ-027 A shared package SHALL hold:
- the FSM state enum (IDLE, RUN, DONE)
- the default WIDTH constant
- the counter width, defined as clog2 of WIDTH.
REQ-028 The per-bit logic SHALL be one sub-module, full_subtractor, with ports a, b, bin, d, bout; it is purely combinational and instantiated once.
REQ-029 The top level SHALL contain only the FSM, counter, shift registers and borrow register.

Verification (WIDTH=8)
REQ-030 a=0x5A, b=0x3C, bin=0 -> done after 8 cycles, diff=0x1E, bout=0.
REQ-031 a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; then a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
REQ-032 start pulsed in cycle 3 of RUN with different operands -> first result unchanged, exactly one done pulse.
REQ-033 rst_n=0 in cycle 4 of RUN -> busy=0, diff=0, bout=0 at the next edge, and no done pulse for 20 cycles.
REQ-034 Back-to-back runs (0x10-0x01, then 0x80-0x80) -> done pulses 9 cycles apart, with results 0x0F/0 then 0x00/0.
REQ-035 Exhaustive check for WIDTH=4 (all a, b, bin) -> every result matches (a - b - bin) mod 16, with the correct borrow.
